// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: datapath widths, ALU opcodes,
// ResultSrc encodings and forward-select codes.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned RES_SRC_W  = 2;
  localparam int unsigned FWD_SEL_W  = 2;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

  typedef enum logic [RES_SRC_W-1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  localparam logic [FWD_SEL_W-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_SEL_W-1:0] FWD_W  = 2'b01;
  localparam logic [FWD_SEL_W-1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational integer ALU: add/sub/and/or/signed slt; unused opcodes yield 0.
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic [WIDTH-1:0]      SrcA,
  input  logic [WIDTH-1:0]      SrcB,
  input  logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [WIDTH-1:0]      ALUResult,
  output logic                  Zero
);

  logic slt;

  assign slt = $signed(SrcA) < $signed(SrcB);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD: ALUResult = SrcA + SrcB;
      ALU_SUB: ALUResult = SrcA - SrcB;
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_OR:  ALUResult = SrcA | SrcB;
      ALU_SLT: ALUResult = WIDTH'(slt);
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: M/W forwarding, ALU, branch/jump resolution and
// the EX/MEM pipeline register.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = XLEN,
  parameter int unsigned ADDRESS_WIDTH = REG_AW
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic                     RegWriteE,
  input  logic                     MemWriteE,
  input  logic                     JumpE,
  input  logic                     BranchE,
  input  logic                     ALUSrcE,
  input  logic [RES_SRC_W-1:0]     ResultSrcE,
  input  logic [ALU_CTRL_W-1:0]    ALUControlE,
  input  logic [ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [ADDRESS_WIDTH-1:0] RdE,
  input  logic [DATA_WIDTH-1:0]    RD1E,
  input  logic [DATA_WIDTH-1:0]    RD2E,
  input  logic [DATA_WIDTH-1:0]    PCE,
  input  logic [DATA_WIDTH-1:0]    ImmExtE,
  input  logic [DATA_WIDTH-1:0]    PCPlus4E,
  input  logic                     RegWriteW,
  input  logic [ADDRESS_WIDTH-1:0] RdW,
  input  logic [DATA_WIDTH-1:0]    ResultW,
  output logic                     PCSrcE,
  output logic [DATA_WIDTH-1:0]    PCTargetE,
  output logic [FWD_SEL_W-1:0]     ForwardAE,
  output logic [FWD_SEL_W-1:0]     ForwardBE,
  output logic                     RegWriteM,
  output logic                     MemWriteM,
  output logic [RES_SRC_W-1:0]     ResultSrcM,
  output logic [ADDRESS_WIDTH-1:0] RdM,
  output logic [DATA_WIDTH-1:0]    ALUResultM,
  output logic [DATA_WIDTH-1:0]    WriteDataM,
  output logic [DATA_WIDTH-1:0]    PCPlus4M
);

  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  zero;
  logic                  m_hit_a, m_hit_b, w_hit_a, w_hit_b;

  // Hazard match: a writer to x0 never forwards; M is newer than W so it wins.
  assign m_hit_a = RegWriteM && (RdM != '0) && (RdM == Rs1E);
  assign m_hit_b = RegWriteM && (RdM != '0) && (RdM == Rs2E);
  assign w_hit_a = RegWriteW && (RdW != '0) && (RdW == Rs1E);
  assign w_hit_b = RegWriteW && (RdW != '0) && (RdW == Rs2E);

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (m_hit_a)      ForwardAE = FWD_M;
    else if (w_hit_a) ForwardAE = FWD_W;
    if (m_hit_b)      ForwardBE = FWD_M;
    else if (w_hit_b) ForwardBE = FWD_W;
  end

  // Operand muxes after forwarding.
  always_comb begin
    src_a      = RD1E;
    write_data = RD2E;
    case (ForwardAE)
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      FWD_W:   write_data = ResultW;
      FWD_M:   write_data = ALUResultM;
      default: write_data = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : write_data;

  alu #(
    .WIDTH(DATA_WIDTH)
  ) u_alu (
    .SrcA      (src_a),
    .SrcB      (src_b),
    .ALUControl(ALUControlE),
    .ALUResult (alu_result),
    .Zero      (zero)
  );

  assign PCSrcE    = JumpE | (BranchE & zero);
  assign PCTargetE = PCE + ImmExtE;

  // EX/MEM register; CLR wins over the incoming instruction.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RdM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
      ALUResultM <= alu_result;
      WriteDataM <= write_data;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the pipelined RV32I core. Consumes the E-suffixed control and data bundle from the decode-to-execute register, resolves RAW hazards by internal forwarding from the Memory and Writeback stages, runs the ALU, and resolves branches and jumps. Latches results into the execute-to-memory pipeline register.

## Interface
- DATA_WIDTH, 32, datapath width
- ADDRESS_WIDTH, 5, register index width
- CLK  in  1  clock; all state updates on rising edge
- CLR  in  1  synchronous active-high reset; clears the EX/MEM register on the next rising edge
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  in  1 each  control from D/E register
- ResultSrcE  in  2  00 ALU result, 01 memory read data, 10 PC+4
- ALUControlE  in  3  ALU operation
- Rs1E, Rs2E, RdE  in  ADDRESS_WIDTH  source and destination indices
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  DATA_WIDTH  operands, PC, immediate, PC+4
- RegWriteW  in  1  writeback-stage write enable
- RdW  in  ADDRESS_WIDTH  writeback-stage destination
- ResultW  in  DATA_WIDTH  writeback-stage result
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  DATA_WIDTH  PCE + ImmExtE (combinational)
- ForwardAE, ForwardBE  out  2  selected forward source: 00 register file, 01 W, 10 M (combinational)
- RegWriteM, MemWriteM  out  1 each  registered control
- ResultSrcM  out  2  registered
- RdM  out  ADDRESS_WIDTH  registered
- ALUResultM, WriteDataM, PCPlus4M  out  DATA_WIDTH  registered

## Operation
- Forward select A: 10 if RegWriteM && RdM != 0 && RdM == Rs1E; else 01 if RegWriteW && RdW != 0 && RdW == Rs1E; else 00. B is the same rule using Rs2E. M takes priority over W.
- SrcAE = mux(ForwardAE: RD1E, ResultW, ALUResultM). WriteDataE = mux(ForwardBE: RD2E, ResultW, ALUResultM).
- SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU operations: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed; result is 32'd1 or 32'd0). Any other code gives 0.
- Add and sub wrap modulo 2^32; no overflow flag.
- ZeroE = (ALUResultE == 0). PCSrcE = JumpE | (BranchE & ZeroE).
- PCTargetE = PCE + ImmExtE, truncated to DATA_WIDTH.
- EX/MEM register captures RegWriteE, MemWriteE, ResultSrcE, ALUResultE, WriteDataE, RdE and PCPlus4E every cycle. It has no stall input.
- Bubbles are handled upstream: a flushed D/E entry arrives with all controls 0 and passes through as a NOP.

## Timing
- Reset: on a rising edge with CLR=1, every registered output goes to 0, including RdM. This takes priority over the incoming data.
- Forwarding compares RdM and RegWriteM as they are after that edge. For one cycle after CLR, no M-stage forwarding occurs.
- Latency: E inputs to M outputs is 1 cycle. PCSrcE, PCTargetE and ForwardAE/BE are valid in the same cycle (combinational).
- Simultaneous M and W matches on the same source index select M (the newer value).
- Rs = 0 never forwards, even if RdM or RdW is 0 with its write enable high.
- CLR mid-stream drops the instruction that would have entered M; the upstream pipeline is not affected by this block.

## Structure
- Shared package riscv_pkg holds:
  - ALU opcode constants (ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101)
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4)
  - Forward select constants (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10)
- One sub-module, alu: combinational, ports SrcA, SrcB, ALUControl, ALUResult, Zero.
- Forwarding, the branch logic and the EX/MEM register stay inline in execute_stage.

## Test plan
- M forward: cycle 1: add x5 with RdE=5, ALUResult 0x10. Cycle 2: Rs1E=5, RD1E=0xDEAD, add with Imm 4 -> ForwardAE=10, ALUResultM=0x14.
- M over W priority: RdM=7 holds 0x100, RdW=7 with ResultW=0x200, Rs2E=7 -> ForwardBE=10, WriteDataM=0x100.
- x0 guard: RegWriteM=1, RdM=0, Rs1E=0, RD1E=0 -> ForwardAE=00, operand 0.
- Branch: BranchE=1, sub with operands 5 and 5, PCE=0x40, ImmExtE=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0x38. Operands 5 and 6 -> PCSrcE=0.
- Signed slt: 0xFFFFFFFF vs 0x00000001 -> ALUResultM=1. Swapped operands -> ALUResultM=0.
- CLR mid-stream: RegWriteE=1, RdE=9 present while CLR=1 at the edge -> RegWriteM=0, RdM=0, ALUResultM=0. The next cycle Rs1E=9 shows ForwardAE=00.
